// File: rtl/micro_pkg.sv
// Shared encodings and constants for the A/B micro-datapath and its controller.
package micro_pkg;

  localparam int unsigned DATA_W     = 4;
  localparam int unsigned SETTLE_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    CHECK  = 3'd2,
    LOAD_B = 3'd3,
    OUT    = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [DATA_W-1:0] B_MATCH   = 4'd8;
  localparam logic [DATA_W-1:0] B_NOMATCH = 4'd13;
  localparam logic [DATA_W-1:0] A_MATCH   = 4'b0101;

  // B-register source for a given mux select
  function automatic logic [DATA_W-1:0] b_value(input logic sel);
    return sel ? B_MATCH : B_NOMATCH;
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Strobe/status bundle between the controller (master) and the A/B datapath (slave).
interface datapath_ctrl_if;
  logic ALoad;
  logic BLoad;
  logic Muxsel;
  logic out_ctrl;
  logic Astatus;

  modport master (output ALoad, output BLoad, output Muxsel, output out_ctrl, input Astatus);
  modport slave  (input ALoad, input BLoad, input Muxsel, input out_ctrl, output Astatus);
endinterface

// File: rtl/micro_datapath.sv
// 4-bit A/B datapath: A loads from din_a, B loads a constant, dout_b copies B.
module micro_datapath
  import micro_pkg::*;
(
  input  logic              clk,
  input  logic [DATA_W-1:0] din_a,
  datapath_ctrl_if.slave    dp,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    dout_d = dout_q;
    if (dp.ALoad)    a_d    = din_a;
    if (dp.BLoad)    b_d    = b_value(dp.Muxsel);
    if (dp.out_ctrl) dout_d = b_q;
  end

  // Data registers are deliberately not reset; the controller never strobes them out of reset.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    dout_q <= dout_d;
  end

  assign dp.Astatus = (a_q == A_MATCH);
  assign dout_b     = dout_q;

endmodule

// File: rtl/sat_counter.sv
// Up-counter with synchronous active-low clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/datapath_ctrl.sv
// Moore sequencer for the A/B datapath: load A, settle, sample status, load B, output, done.
module datapath_ctrl
  import micro_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  datapath_ctrl_if.master  dp,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                sel_q, sel_d;
  logic                aload_q, aload_d;
  logic                bload_q, bload_d;
  logic                muxsel_q, muxsel_d;
  logic                out_ctrl_q, out_ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                match_inc_c;

  // Next-state logic; strobes are registered from the next state so each is a clean flop output
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    sel_d       = sel_q;
    match_inc_c = 1'b0;

    case (state_q)
      IDLE:   if (start) state_d = LOAD_A;
      LOAD_A: begin
        state_d  = CHECK;
        settle_d = '0;
      end
      CHECK: begin
        if (settle_q == SETTLE_LAST) begin
          sel_d       = dp.Astatus;
          match_inc_c = dp.Astatus;
          state_d     = LOAD_B;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      LOAD_B:  state_d = OUT;
      OUT:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    aload_d    = (state_d == LOAD_A);
    bload_d    = (state_d == LOAD_B);
    muxsel_d   = (state_d == LOAD_B) && sel_d;
    out_ctrl_d = (state_d == OUT);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      sel_q      <= 1'b0;
      aload_q    <= 1'b0;
      bload_q    <= 1'b0;
      muxsel_q   <= 1'b0;
      out_ctrl_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      sel_q      <= sel_d;
      aload_q    <= aload_d;
      bload_q    <= bload_d;
      muxsel_q   <= muxsel_d;
      out_ctrl_q <= out_ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clock),
    .clr_n (reset_n),
    .inc   (match_inc_c),
    .count (match_count)
  );

  assign dp.ALoad    = aload_q;
  assign dp.BLoad    = bload_q;
  assign dp.Muxsel   = muxsel_q;
  assign dp.out_ctrl = out_ctrl_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench: controller + datapath pairs at SETTLE=1, SETTLE=3 and a 2-bit match counter.
module tb_datapath_ctrl;
  import micro_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] din_a;

  always #5 clk = ~clk;

  datapath_ctrl_if if1();
  datapath_ctrl_if if3();
  datapath_ctrl_if ifs();

  logic       busy1, done1, busy3, done3, busys, dones;
  logic [7:0] cnt1, cnt3;
  logic [1:0] cnts;
  logic [3:0] dout1, dout3, douts;

  datapath_ctrl #(.SETTLE(1), .CNT_W(8)) dut1 (
    .clock(clk), .reset_n(reset_n), .start(start), .dp(if1),
    .busy(busy1), .done(done1), .match_count(cnt1));
  micro_datapath dp1 (.clk(clk), .din_a(din_a), .dp(if1), .dout_b(dout1));

  datapath_ctrl #(.SETTLE(3), .CNT_W(8)) dut3 (
    .clock(clk), .reset_n(reset_n), .start(start), .dp(if3),
    .busy(busy3), .done(done3), .match_count(cnt3));
  micro_datapath dp3 (.clk(clk), .din_a(din_a), .dp(if3), .dout_b(dout3));

  datapath_ctrl #(.SETTLE(1), .CNT_W(2)) duts (
    .clock(clk), .reset_n(reset_n), .start(start), .dp(ifs),
    .busy(busys), .done(dones), .match_count(cnts));
  micro_datapath dps (.clk(clk), .din_a(din_a), .dp(ifs), .dout_b(douts));

  // {ALoad, BLoad, Muxsel, out_ctrl, busy, done}
  logic [5:0] s1, s3, ss;
  assign s1 = {if1.ALoad, if1.BLoad, if1.Muxsel, if1.out_ctrl, busy1, done1};
  assign s3 = {if3.ALoad, if3.BLoad, if3.Muxsel, if3.out_ctrl, busy3, done3};
  assign ss = {ifs.ALoad, ifs.BLoad, ifs.Muxsel, ifs.out_ctrl, busys, dones};

  typedef struct {
    logic       start;
    logic [3:0] din;
    logic [5:0] strb;
    logic       chk_dout;
    logic [3:0] dout;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [12];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Steps until the selected instance raises done; returns steps taken or -1 on timeout
  task automatic wait_done(input int which, output int steps);
    logic d;
    steps = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      d = (which == 1) ? done1 : (which == 3) ? done3 : dones;
      if (d) begin
        steps = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int last;
    int ndone;
    int de;
    int sat_exp [4];

    reset_n = 1'b0;
    start   = 1'b0;
    din_a   = 4'd0;

    // Match then no-match at SETTLE=1; start in CHECK (row 8) must be ignored
    vecs[0]  = '{1'b1, 4'd5, 6'b100010, 1'b0, 4'd0,  8'd0};
    vecs[1]  = '{1'b0, 4'd5, 6'b000010, 1'b0, 4'd0,  8'd0};
    vecs[2]  = '{1'b0, 4'd5, 6'b011010, 1'b0, 4'd0,  8'd1};
    vecs[3]  = '{1'b0, 4'd5, 6'b000110, 1'b0, 4'd0,  8'd1};
    vecs[4]  = '{1'b0, 4'd5, 6'b000011, 1'b1, 4'd8,  8'd1};
    vecs[5]  = '{1'b0, 4'd5, 6'b000000, 1'b1, 4'd8,  8'd1};
    vecs[6]  = '{1'b1, 4'd3, 6'b100010, 1'b0, 4'd0,  8'd1};
    vecs[7]  = '{1'b0, 4'd3, 6'b000010, 1'b0, 4'd0,  8'd1};
    vecs[8]  = '{1'b1, 4'd3, 6'b010010, 1'b0, 4'd0,  8'd1};
    vecs[9]  = '{1'b0, 4'd3, 6'b000110, 1'b0, 4'd0,  8'd1};
    vecs[10] = '{1'b0, 4'd3, 6'b000011, 1'b1, 4'd13, 8'd1};
    vecs[11] = '{1'b0, 4'd3, 6'b000000, 1'b1, 4'd13, 8'd1};

    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3;

    // Reset state
    do_reset();
    check("reset s1 outputs", 32'(s1), 0);
    check("reset s3 outputs", 32'(s3), 0);
    check("reset ss outputs", 32'(ss), 0);
    check("reset cnt1", 32'(cnt1), 0);
    check("reset cnts", 32'(cnts), 0);

    // Table-driven single transactions
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start;
      din_a = vecs[i].din;
      step();
      check($sformatf("vec%0d strobes", i), 32'(s1), 32'(vecs[i].strb));
      check($sformatf("vec%0d match_count", i), 32'(cnt1), 32'(vecs[i].cnt));
      if (vecs[i].chk_dout) check($sformatf("vec%0d dout_b", i), 32'(dout1), 32'(vecs[i].dout));
    end

    // SETTLE=3: A changes after it is loaded; result follows the loaded value
    do_reset();
    din_a = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    check("s3 load_a strobes", 32'(s3), 32'(6'b100010));
    step();
    din_a = 4'd2;
    de = -1;
    for (int e = 2; e < 20; e++) begin
      step();
      if (if3.BLoad) check("s3 muxsel in load_b", 32'(if3.Muxsel), 1);
      if (done3) begin
        de = e;
        break;
      end
    end
    check("s3 done cycle", de + 1, 7);
    check("s3 dout_b", 32'(dout3), 8);
    check("s3 match_count", 32'(cnt3), 1);

    // Reset during LOAD_B
    do_reset();
    din_a = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rst pre load_b strobes", 32'(s1), 32'(6'b011010));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rst outputs cleared", 32'(s1), 0);
    check("rst match_count cleared", 32'(cnt1), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst no out_ctrl", 32'(if1.out_ctrl), 0);
      check("rst stays idle", 32'(busy1), 0);
    end
    din_a = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, n);
    check("rst rerun latency", n, 4);
    check("rst rerun dout_b", 32'(dout1), 13);
    check("rst rerun match_count", 32'(cnt1), 0);
    step();

    // start held high, DinA alternating 5/6
    do_reset();
    din_a = 4'd5;
    start = 1'b1;
    last  = -1;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      step();
      check("b2b strobe overlap", 32'($countones({if1.ALoad, if1.BLoad, if1.out_ctrl}) <= 1), 1);
      if (done1) begin
        check($sformatf("b2b dout_b %0d", ndone), 32'(dout1), (ndone % 2 == 0) ? 8 : 13);
        if (ndone == 0) check("b2b first done cycle", c + 1, 5);
        else            check($sformatf("b2b period %0d", ndone), c - last, 6);
        last  = c;
        ndone++;
        din_a = (ndone % 2 == 0) ? 4'd5 : 4'd6;
      end
    end
    start = 1'b0;
    check("b2b done count", ndone, 4);
    check("b2b match_count", 32'(cnt1), 2);

    // 2-bit match counter saturates
    do_reset();
    din_a = 4'd5;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(2, n);
      check($sformatf("sat latency %0d", i), n, 4);
      check($sformatf("sat match_count %0d", i), 32'(cnts), sat_exp[i]);
      check($sformatf("sat dout_b %0d", i), 32'(douts), 8);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Moore-style controller that sequences the 4-bit A/B datapath: it loads A from DinA, waits a settle window, samples the datapath's A-equals-5 status, loads B with the selected constant, then transfers B to DoutB. It sits directly upstream of the datapath. It drives the datapath's ALoad, BLoad, Muxsel and out_ctrl inputs and consumes its Astatus output. A start/busy/done handshake lets a higher-level sequencer launch one transaction at a time, and a saturating counter tracks how many transactions saw a match.

## Interface
- SETTLE, default 1: cycles spent in CHECK before Astatus is sampled; legal range 1..15.
- CNT_W, default 8: width of match_count.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  in  1  transaction request; sampled only in IDLE.
- Astatus  in  1  datapath status, 1 when register A == 4'b0101.
- ALoad  out  1  datapath A-register load strobe.
- BLoad  out  1  datapath B-register load strobe.
- Muxsel  out  1  B source select: 1 loads B=8, 0 loads B=13.
- out_ctrl  out  1  datapath DoutB update strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE; DoutB is valid in that cycle.
- match_count  out  CNT_W  saturating count of transactions with Astatus=1.

## Operation
- States: IDLE, LOAD_A, CHECK, LOAD_B, OUT, DONE. The state register is binary-encoded.
- IDLE -> LOAD_A when start=1; otherwise stay in IDLE.
- LOAD_A -> CHECK unconditionally. ALoad=1 in LOAD_A.
- CHECK:
  - Holds for SETTLE cycles, counted by a 4-bit settle counter that clears on entry.
  - In the last CHECK cycle, Astatus is registered into sel_q; then the state moves to LOAD_B.
  - If sel_q is set, match_count increments in the same edge, saturating at all-ones.
- LOAD_B -> OUT. BLoad=1 and Muxsel=sel_q in LOAD_B.
- OUT -> DONE. out_ctrl=1 in OUT.
- DONE -> IDLE. done=1 in DONE.
- Output rules:
  - All strobes decode from the state register only, with no combinational path from inputs.
  - At most one of ALoad, BLoad and out_ctrl is high in any cycle, so the datapath's exclusive-strobe qualifiers are always met.
  - Muxsel is 0 in every state except LOAD_B.
- start outside IDLE is ignored; it is not queued. A start held high through DONE launches the next transaction from IDLE with no extra gap.
- Astatus is not used outside the last CHECK cycle.

## Timing
- Reset (reset_n=0 at an edge):
  - state becomes IDLE, and settle counter, sel_q and match_count become 0.
  - ALoad, BLoad, Muxsel, out_ctrl, busy and done are all 0 in the following cycle.
  - This applies mid-transaction too. The datapath A and B registers are not reset by this block, and no partial strobe is issued after reset.
- Cycle schedule, with start sampled high at edge 0:
  - LOAD_A occupies cycle 1.
  - CHECK occupies cycles 2..1+SETTLE.
  - LOAD_B occupies cycle 2+SETTLE, OUT cycle 3+SETTLE, and DONE cycle 4+SETTLE.
  - Total start-to-done latency is 4+SETTLE cycles.
- The A register updates at the end of cycle 1, so Astatus is stable from cycle 2. This is why SETTLE >= 1.
- DoutB updates at the end of the OUT cycle and is valid when done=1.
- The minimum back-to-back period is 5+SETTLE cycles.
- match_count updates at the edge leaving CHECK and holds its value across reset-free idle periods.

## Structure
- Shared package micro_pkg holds:
  - the state encodings: IDLE=0, LOAD_A=1, CHECK=2, LOAD_B=3, OUT=4, DONE=5;
  - the constants B_MATCH=4'd8, B_NOMATCH=4'd13 and A_MATCH=4'b0101.
- The datapath should reference the same micro_pkg constants.
- One sub-module, sat_counter (parameter W): synchronous active-low clear, an increment enable, and saturation at all-ones. It is used for match_count.
- The settle counter stays inline.
- The top-level integration instantiates datapath_ctrl and the datapath side by side, with the strobes wired one-to-one.

## Test plan
- DinA=4'b0101, start pulse, SETTLE=1 -> strobe order ALoad, then BLoad with Muxsel=1, then out_ctrl over cycles 1..4; done in cycle 5 with DoutB=8; match_count=1.
- DinA=4'b0011, start pulse -> Muxsel=0 during LOAD_B; DoutB=13 at done; match_count unchanged.
- SETTLE=3, DinA changed from 5 to 2 during CHECK -> Astatus is sampled in the last CHECK cycle only; done in cycle 7; DoutB reflects A loaded in cycle 1 (=8).
- reset_n=0 during LOAD_B -> all outputs 0 in the next cycle, state IDLE, match_count=0, no out_ctrl pulse; a new start runs normally.
- start held high continuously with alternating DinA 5/6 -> no strobe overlap; done every 6 cycles; DoutB alternates 8/13.
- CNT_W=2, four matching transactions -> match_count goes 1, 2, 3, 3 (saturates).
